// File: rtl/iq_accum_serializer.sv
// Four-channel I/Q decimating accumulator: sums 2^decim_shift strobes per window,
// scales and saturates the eight results, then emits them as an 8-word serial burst.
module iq_accum_serializer #(
    parameter int IW = 18,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [IW-1:0] i_in0,
    input  logic signed [IW-1:0] i_in1,
    input  logic signed [IW-1:0] i_in2,
    input  logic signed [IW-1:0] i_in3,
    input  logic signed [IW-1:0] q_in0,
    input  logic signed [IW-1:0] q_in1,
    input  logic signed [IW-1:0] q_in2,
    input  logic signed [IW-1:0] q_in3,
    input  logic                 strobe_in,
    input  logic [3:0]           decim_shift,
    output logic signed [DW-1:0] stream_out,
    output logic                 strobe_out,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int unsigned AW  = IW + 15;
    localparam int unsigned CW  = 15;
    localparam int unsigned NCH = 8;
    localparam int unsigned XW  = 3;

    localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [XW-1:0] idx_q, idx_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    shift_q, shift_d;
    logic signed [AW-1:0] acc_q [NCH];
    logic signed [AW-1:0] acc_d [NCH];
    logic signed [DW-1:0] wbuf_q [NCH-1];
    logic signed [DW-1:0] wbuf_d [NCH-1];
    logic signed [DW-1:0] stream_q, stream_d;
    logic                 strobe_q, strobe_d;
    logic                 overrun_q, overrun_d;

    logic signed [IW-1:0] samp_c [NCH];
    logic signed [AW-1:0] sum_c [NCH];
    logic signed [AW-1:0] scaled_c [NCH];
    logic signed [DW-1:0] res_c [NCH];
    logic                 start_c;
    logic [3:0]           eff_shift_c;
    logic [CW-1:0]        last_cnt_c;
    logic                 complete_c;
    logic                 capture_c;
    logic                 drop_c;

    // Word order I0, Q0, I1, Q1, I2, Q2, I3, Q3
    assign samp_c[0] = i_in0;
    assign samp_c[1] = q_in0;
    assign samp_c[2] = i_in1;
    assign samp_c[3] = q_in1;
    assign samp_c[4] = i_in2;
    assign samp_c[5] = q_in2;
    assign samp_c[6] = i_in3;
    assign samp_c[7] = q_in3;

    // Window bookkeeping; the first strobe of a window uses the live shift before it is latched
    always_comb begin
        start_c     = (cnt_q == '0);
        eff_shift_c = start_c ? decim_shift : shift_q;
        last_cnt_c  = ~({CW{1'b1}} << eff_shift_c);
        complete_c  = strobe_in && (cnt_q == last_cnt_c);
        capture_c   = complete_c && (state_q == ST_IDLE);
        drop_c      = complete_c && (state_q == ST_SHIFT);
    end

    // Running sums including the current sample, scaled and saturated
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            sum_c[i]    = (start_c ? '0 : acc_q[i]) + AW'(samp_c[i]);
            scaled_c[i] = sum_c[i] >>> eff_shift_c;
            if (scaled_c[i] > SAT_MAX) begin
                res_c[i] = DW'(SAT_MAX);
            end else if (scaled_c[i] < SAT_MIN) begin
                res_c[i] = DW'(SAT_MIN);
            end else begin
                res_c[i] = DW'(scaled_c[i]);
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        overrun_d = overrun_q;
        for (int i = 0; i < int'(NCH); i++) begin
            acc_d[i] = acc_q[i];
        end
        for (int i = 0; i < int'(NCH) - 1; i++) begin
            wbuf_d[i] = wbuf_q[i];
        end

        if (strobe_in) begin
            for (int i = 0; i < int'(NCH); i++) begin
                acc_d[i] = sum_c[i];
            end
            cnt_d = complete_c ? '0 : cnt_q + CW'(1);
            if (start_c) begin
                shift_d = decim_shift;
            end
        end

        // Word 0 goes straight to the output register; the rest wait here
        if (capture_c) begin
            for (int i = 0; i < int'(NCH) - 1; i++) begin
                wbuf_d[i] = res_c[i+1];
            end
        end

        if (drop_c) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                acc_q[i] <= '0;
            end
            for (int i = 0; i < int'(NCH) - 1; i++) begin
                wbuf_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < int'(NCH); i++) begin
                acc_q[i] <= acc_d[i];
            end
            for (int i = 0; i < int'(NCH) - 1; i++) begin
                wbuf_q[i] <= wbuf_d[i];
            end
        end
    end

    // Serializer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            stream_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stream_q <= stream_d;
            strobe_q <= strobe_d;
        end
    end

    // Next state: SHIFT index k is the cycle in which word k is on the output
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_c) begin
                    state_d = ST_SHIFT;
                    idx_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (idx_q == XW'(NCH - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + XW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output words are registered one step ahead of the state index
    always_comb begin
        stream_d = stream_q;
        strobe_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_c) begin
                    stream_d = res_c[0];
                    strobe_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (idx_q != XW'(NCH - 1)) begin
                    stream_d = wbuf_q[idx_q];
                    strobe_d = 1'b1;
                end
            end
            default: begin
                strobe_d = 1'b0;
            end
        endcase
    end

    assign stream_out = stream_q;
    assign strobe_out = strobe_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_iq_accum_serializer.sv
// Bench for iq_accum_serializer: directed scenarios plus random traffic against a
// transaction-level model (window sums, expected word queue, sticky overrun bit).
module tb_iq_accum_serializer;

    localparam int IW = 18;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [IW-1:0] ii [4];
    logic signed [IW-1:0] qq [4];
    logic                 strobe_in;
    logic [3:0]           decim_shift;
    logic signed [DW-1:0] stream_out;
    logic                 strobe_out;
    logic                 overrun;
    logic                 overrun_clr;

    always #5 clk = ~clk;

    iq_accum_serializer #(.IW(IW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in0       (ii[0]),
        .i_in1       (ii[1]),
        .i_in2       (ii[2]),
        .i_in3       (ii[3]),
        .q_in0       (qq[0]),
        .q_in1       (qq[1]),
        .q_in2       (qq[2]),
        .q_in3       (qq[3]),
        .strobe_in   (strobe_in),
        .decim_shift (decim_shift),
        .stream_out  (stream_out),
        .strobe_out  (strobe_out),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int     exp_q [$];
    int     last_word;
    bit     ov_m;
    longint m_cnt;
    int     m_shift;
    longint sums [8];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_word = 0;
        ov_m      = 1'b0;
        m_cnt     = 0;
        m_shift   = 0;
        for (int k = 0; k < 8; k++) sums[k] = 0;
    endtask

    function automatic int scale_sat(input longint v, input int sh);
        longint r;
        longint hi;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        r  = v >>> sh;
        if (r > hi) r = hi;
        if (r < -hi - 1) r = -hi - 1;
        return int'(r);
    endfunction

    // Drive one cycle, check the outputs of the current cycle, then advance the model
    task automatic step(input bit stb, input int ds, input bit clr, input int s[8]);
        bit busy;
        bit drop;
        int w;
        strobe_in   = stb;
        decim_shift = 4'(ds);
        overrun_clr = clr;
        for (int k = 0; k < 4; k++) begin
            ii[k] = IW'(s[2*k]);
            qq[k] = IW'(s[2*k+1]);
        end
        @(negedge clk);
        busy = (exp_q.size() > 0);
        if (busy) begin
            w = exp_q.pop_front();
            check("strobe_out_burst", longint'(strobe_out), 1);
            check("stream_word", longint'(stream_out), longint'(w));
            last_word = w;
        end else begin
            check("strobe_out_idle", longint'(strobe_out), 0);
            check("stream_hold", longint'(stream_out), longint'(last_word));
        end
        check("overrun", longint'(overrun), longint'(ov_m));

        drop = 1'b0;
        if (stb) begin
            if (m_cnt == 0) begin
                m_shift = ds;
                for (int k = 0; k < 8; k++) sums[k] = longint'(s[k]);
            end else begin
                for (int k = 0; k < 8; k++) sums[k] += longint'(s[k]);
            end
            m_cnt++;
            if (m_cnt == (longint'(1) <<< m_shift)) begin
                m_cnt = 0;
                if (busy) drop = 1'b1;
                else for (int k = 0; k < 8; k++) exp_q.push_back(scale_sat(sums[k], m_shift));
            end
        end
        if (drop) ov_m = 1'b1;
        else if (clr) ov_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_samp();
        if ($urandom_range(0, 3) == 0)
            return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    task automatic idle(input int n, input int ds);
        int s[8];
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 8; k++) s[k] = rnd_samp();
            step(1'b0, ds, 1'b0, s);
        end
    endtask

    task automatic rnd_strobe(input int ds, input bit clr);
        int s[8];
        for (int k = 0; k < 8; k++) s[k] = rnd_samp();
        step(1'b1, ds, clr, s);
    endtask

    initial begin
        int s[8];
        rst         = 1'b1;
        strobe_in   = 1'b0;
        decim_shift = '0;
        overrun_clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ii[k] = '0;
            qq[k] = '0;
        end
        model_reset();
        #1;
        check("rst_strobe_out", longint'(strobe_out), 0);
        check("rst_stream_out", longint'(stream_out), 0);
        check("rst_overrun", longint'(overrun), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // N=1 ramp
        s = '{1, 2, 3, 4, -1, -2, -3, -4};
        step(1'b1, 0, 1'b0, s);
        idle(10, 0);

        // N=4 positive and floor rounding on I0
        s = '{default: 0};
        for (int c = 0; c < 4; c++) begin
            s[0] = 10 + c;
            step(1'b1, 2, 1'b0, s);
        end
        idle(10, 2);
        s = '{-1, 0, 0, 0, 0, 0, 0, 0};
        for (int c = 0; c < 4; c++) begin
            s[0] = (c == 3) ? -2 : -1;
            step(1'b1, 2, 1'b0, s);
        end
        idle(10, 2);

        // Saturation
        s = '{40000, -40000, 0, 0, 0, 0, 0, 0};
        step(1'b1, 0, 1'b0, s);
        idle(10, 0);

        // Overrun: strobes every 4 cycles drop the ones landing inside a burst
        for (int r = 0; r < 4; r++) begin
            rnd_strobe(0, 1'b0);
            idle(3, 0);
        end
        idle(8, 0);
        s = '{default: 0};
        step(1'b0, 0, 1'b1, s);
        idle(2, 0);
        // Clear coincident with a fresh drop: set wins
        rnd_strobe(0, 1'b0);
        idle(3, 0);
        rnd_strobe(0, 1'b1);
        idle(10, 0);
        step(1'b0, 0, 1'b1, s);
        idle(2, 0);

        // Reset during burst index 3
        rnd_strobe(0, 1'b0);
        idle(3, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_strobe_out", longint'(strobe_out), 0);
        check("rst_mid_stream_out", longint'(stream_out), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3, 2);
        for (int c = 0; c < 4; c++) rnd_strobe(2, 1'b0);
        idle(10, 2);

        // Shift change mid-window: still N=4, next window N=1
        rnd_strobe(2, 1'b0);
        for (int c = 0; c < 3; c++) rnd_strobe(0, 1'b0);
        idle(10, 0);
        rnd_strobe(0, 1'b0);
        idle(10, 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            int ds;
            ds = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            for (int k = 0; k < 8; k++) s[k] = rnd_samp();
            step(($urandom_range(0, 2) != 0), ds, ($urandom_range(0, 15) == 0), s);
        end
        idle(12, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iq_accum_serializer.md
IQ_ACCUM_SERIALIZER -- requirements
Module: iq_accum_serializer

Interface
REQ-001 SHALL have parameter IW, default 18: input sample width, signed two's complement.
REQ-002 SHALL have parameter DW, default 16: output word width, signed two's complement.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have ports i_in0..i_in3, q_in0..q_in3  input  IW each: parallel I/Q samples of channels 0..3.
REQ-006 SHALL have port strobe_in  input  1: all eight inputs valid this cycle.
REQ-007 SHALL have port decim_shift  input  4: decimation N = 2^decim_shift (N = 1..32768).
REQ-008 SHALL have port stream_out  output  DW: serialized word stream.
REQ-009 SHALL have port strobe_out  output  1: stream_out valid this cycle.
REQ-010 SHALL have port overrun  output  1: sticky flag, a completed result was dropped.
REQ-011 SHALL have port overrun_clr  input  1: synchronous clear of overrun.

Function
REQ-012 SHALL keep eight signed accumulators of width IW+15 and one sample counter cnt.
REQ-013 On strobe_in with cnt==0: accumulators load the samples; decim_shift is latched as the window's shift.
REQ-014 On strobe_in with cnt!=0: accumulators add the samples.
REQ-015 Each strobe_in increments cnt; on the strobe where cnt==N-1, the window completes and cnt returns to 0.
REQ-016 A decim_shift change mid-window has no effect until the next window start.
REQ-017 At completion, each result = (accumulator + current sample) arithmetic-shifted right by the latched shift (floor), then saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-018 At completion, the eight results are captured into an output buffer on the same clock edge.
REQ-019 States: IDLE, SHIFT (index 0..7).
REQ-020 IDLE -> SHIFT on capture; SHIFT advances by one index per cycle; SHIFT -> IDLE after index 7.
REQ-021 Latency: strobe_in of the completing sample at cycle t gives the first word at t+1.
REQ-022 strobe_out SHALL be high for exactly 8 consecutive cycles, t+1..t+8.
REQ-023 Word order: I0, Q0, I1, Q1, I2, Q2, I3, Q3.
REQ-024 Outside SHIFT, strobe_out=0 and stream_out holds its last value.
REQ-025 A completion occurring while in SHIFT, including at index 7: the new result is dropped, the current burst continues unchanged, and overrun is set.
REQ-026 Accumulation continues normally during SHIFT.
REQ-027 Simultaneous overrun set and overrun_clr: set wins.
REQ-028 strobe_in while not completing never affects the output path.

Reset
REQ-029 rst asserted SHALL immediately force: cnt=0, accumulators=0, state=IDLE, strobe_out=0, stream_out=0, overrun=0, latched shift=0.
REQ-030 rst asserted mid-burst SHALL abort the burst with no further strobe_out.
REQ-031 After rst deasserts, the first strobe_in starts a new window.

Verification
REQ-032 Scenario N=1: decim_shift=0; one strobe with I0..Q3 = 1,2,3,4,-1,-2,-3,-4 -> the next 8 cycles give stream_out 1,2,3,4,-1,-2,-3,-4 with strobe_out high for exactly 8 cycles.
REQ-033 Scenario N=4: decim_shift=2; four strobes with i_in0 = 10,11,12,13 -> I0 word = 11 (46>>>2); with i_in0 = -1,-1,-1,-2 -> I0 word = -2 (floor).
REQ-034 Scenario saturation: N=1, i_in0=+40000, q_in0=-40000 -> words 32767 and -32768.
REQ-035 Scenario overrun: N=1, strobes every 4 cycles -> the second result is dropped and the first burst is intact; overrun=1 until overrun_clr pulse; clr coincident with a new drop leaves overrun=1.
REQ-036 Scenario reset: rst pulse during SHIFT index 3 -> strobe_out=0 from assertion; a full N=4 window after release yields a correct burst.
REQ-037 Scenario shift change: decim_shift changed 2->0 mid-window -> the current window still uses N=4; the next window uses N=1.
